// File: rtl/led_frame_receiver.sv
// led_frame_receiver: receives the LED pixel link and stores each frame into a read buffer; FRAME_DOUBLE_BUFFER_EN keeps a shadow buffer so the read port only ever shows whole frames.
// The read port is read-first: a read of the byte being written this cycle returns the old contents.
module led_frame_receiver #(
  parameter int FRAME_BYTES = 16,
  parameter logic [7:0] HDR_BYTE = 8'hF1,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int AW = $clog2(FRAME_BYTES),
  localparam int TW = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_SCK,
  input  logic          i_SDA,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [7:0]    o_byte,
  output logic          o_byte_valid,
  output logic          o_frame_done,
  output logic          o_frame_err,
  output logic          o_busy
);
  typedef enum logic {WAIT_HDR, RECV_DATA} state_t;
  state_t state, nxt;
  logic [2:0] sck_s;
  logic [1:0] sda_s;
  logic [6:0] sh;
  logic [2:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] idx;
  logic [7:0] rd_mem [FRAME_BYTES];
  logic rise, byte_done, expire, hdr_hit, we, done, err;
  logic [7:0] nb;
  always_comb begin
    rise = sck_s[1] & ~sck_s[2];
    nb = {sh, sda_s[1]};
    byte_done = rise && bit_cnt == 3'd7;
    expire = !rise && to_cnt == TW'(IDLE_TIMEOUT - 1);
    hdr_hit = state == WAIT_HDR && byte_done && nb == HDR_BYTE;
    we = state == RECV_DATA && byte_done;
    done = we && idx == AW'(FRAME_BYTES - 1);
    err = state == RECV_DATA && expire;
    nxt = hdr_hit ? RECV_DATA : (done || err) ? WAIT_HDR : state;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= WAIT_HDR;
      sck_s <= '0;
      sda_s <= '0;
      sh <= '0;
      bit_cnt <= '0;
      to_cnt <= '0;
      idx <= '0;
      o_byte <= '0;
      o_byte_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err <= 1'b0;
      o_rd_data <= '0;
    end else begin
      state <= nxt;
      sck_s <= {sck_s[1:0], i_SCK};
      sda_s <= {sda_s[0], i_SDA};
      if (rise) sh <= nb[6:0];
      bit_cnt <= rise ? bit_cnt + 3'd1 : expire ? 3'd0 : bit_cnt;
      to_cnt <= rise ? '0 : (to_cnt == TW'(IDLE_TIMEOUT)) ? to_cnt : to_cnt + 1'b1;
      idx <= hdr_hit ? '0 : we ? idx + 1'b1 : idx;
      if (byte_done) o_byte <= nb;
      o_byte_valid <= byte_done;
      o_frame_done <= done;
      o_frame_err <= err;
      o_rd_data <= rd_mem[i_rd_addr];
    end
  end
  assign o_busy = state == RECV_DATA;
`ifdef FRAME_DOUBLE_BUFFER_EN
  logic [7:0] shadow [FRAME_BYTES];
  // the final byte bypasses the shadow so the copy sees the complete frame
  always_ff @(posedge CLK) begin
    if (we) shadow[idx] <= nb;
    if (done) for (int i = 0; i < FRAME_BYTES; i++) rd_mem[i] <= (AW'(i) == idx) ? nb : shadow[i];
  end
`else
  always_ff @(posedge CLK) begin
    if (we) rd_mem[idx] <= nb;
  end
`endif
endmodule

// File: tb/tb_led_frame_receiver.sv
// tb_led_frame_receiver: directed self-checking bench for led_frame_receiver at SCK = CLK/8.
module tb_led_frame_receiver;
  logic CLK = 1'b0, RST = 1'b1, SCK = 1'b0, SDA = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data, o_byte;
  logic byte_valid, frame_done, frame_err, busy;
  int tests = 0, fails = 0;
  int n_valid = 0, n_done = 0, n_err = 0, n_busy = 0;
  logic [7:0] last_b = '0, prev_b = '0;
  int b_valid, b_done, b_err, b_busy;
  typedef struct {logic [3:0] addr; logic [7:0] exp;} rd_vec_t;
  rd_vec_t tbl [16];

  led_frame_receiver dut (
    .CLK(CLK), .RST(RST), .i_SCK(SCK), .i_SDA(SDA), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_byte(o_byte), .o_byte_valid(byte_valid),
    .o_frame_done(frame_done), .o_frame_err(frame_err), .o_busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (byte_valid) begin
      n_valid++;
      prev_b = last_b;
      last_b = o_byte;
    end
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (busy) n_busy++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_done = n_done; b_err = n_err; b_busy = n_busy;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      SDA = b[7-i];
      repeat (4) @(posedge CLK);
      SCK = 1'b1;
      repeat (4) @(posedge CLK);
      SCK = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic send_frame();
    send_byte(8'hF1);
    for (int i = 0; i < 16; i++) send_byte(tbl[i].exp);
    repeat (8) @(posedge CLK);
  endtask

  task automatic check_reads(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) rd_addr = tbl[i].addr;
      @(posedge CLK);
      #1 chk($sformatf("%s_rd%0d", nm, i), {24'h0, rd_data}, {24'h0, tbl[i].exp});
    end
  endtask

  task automatic check_frame(input string nm);
    chk({nm, "_valid"}, n_valid - b_valid, 17);
    chk({nm, "_done"}, n_done - b_done, 1);
    chk({nm, "_err"}, n_err - b_err, 0);
    chk({nm, "_busy_end"}, {31'h0, busy}, 0);
    check_reads(nm, 16);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_byte", {24'h0, o_byte}, 0);
    chk("rst_valid", {31'h0, byte_valid}, 0);
    chk("rst_done", {31'h0, frame_done}, 0);
    chk("rst_err", {31'h0, frame_err}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_rd", {24'h0, rd_data}, 0);
    @(negedge CLK) RST = 1'b0;

    // frame of alternating 00/55
    for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), (i % 2 == 1) ? 8'h55 : 8'h00};
    snap();
    send_byte(8'hF1);
    repeat (6) @(posedge CLK);
    #1 chk("alt_busy_mid", {31'h0, busy}, 1);
    for (int i = 0; i < 16; i++) send_byte(tbl[i].exp);
    repeat (8) @(posedge CLK);
    chk("alt_last_byte", {24'h0, last_b}, 8'h55);
    check_frame("alt");

    // stray bytes outside a frame, then a long idle in WAIT_HDR
    snap();
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (1100) @(posedge CLK);
    chk("stray_valid", n_valid - b_valid, 2);
    chk("stray_first", {24'h0, prev_b}, 8'h12);
    chk("stray_second", {24'h0, last_b}, 8'h34);
    chk("stray_done", n_done - b_done, 0);
    chk("stray_busy", n_busy - b_busy, 0);
    chk("idle_no_err", n_err - b_err, 0);

    // header + 5 bytes, then timeout
    snap();
    send_byte(8'hF1);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    repeat (1000) @(posedge CLK);
    chk("to_early_err", n_err - b_err, 0);
    #1 chk("to_early_busy", {31'h0, busy}, 1);
    repeat (40) @(posedge CLK);
    chk("to_err", n_err - b_err, 1);
    chk("to_done", n_done - b_done, 0);
    #1 chk("to_busy", {31'h0, busy}, 0);
`ifdef FRAME_DOUBLE_BUFFER_EN
    for (int i = 0; i < 5; i++) tbl[i] = '{4'(i), (i % 2 == 1) ? 8'h55 : 8'h00};
`else
    for (int i = 0; i < 5; i++) tbl[i] = '{4'(i), 8'hA0 + 8'(i)};
`endif
    check_reads("to_keep", 5);
    for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), 8'h10 + 8'(i)};
    snap();
    send_frame();
    check_frame("after_to");

    // header + 3 stray bits, timeout, then a clean frame
    snap();
    send_byte(8'hF1);
    send_bits(8'hE0, 3);
    repeat (1040) @(posedge CLK);
    chk("bits_err", n_err - b_err, 1);
    for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), 8'(i * 3 + 1)};
    snap();
    send_frame();
    check_frame("bits");

    // header value as data at index 7
    for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), (i == 7) ? 8'hF1 : 8'h80 + 8'(i)};
    snap();
    send_frame();
    check_frame("hdr_data");

    // reset mid-frame at byte index 9
    snap();
    send_byte(8'hF1);
    for (int i = 0; i < 9; i++) send_byte(8'hC0 + 8'(i));
    #1 chk("mid_busy", {31'h0, busy}, 1);
    @(negedge CLK) RST = 1'b1;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_byte", {24'h0, o_byte}, 0);
    chk("mid_rst_rd", {24'h0, rd_data}, 0);
    @(negedge CLK) RST = 1'b0;
    repeat (200) @(posedge CLK);
    chk("mid_no_done", n_done - b_done, 0);
    chk("mid_no_err", n_err - b_err, 0);
    for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), 8'h3C ^ 8'(i * 17)};
    snap();
    send_frame();
    check_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
